// File: rtl/alu_op_queue.sv
// Operand/opcode FIFO feeding the 4-bit ALU tile over a valid/ready handshake.
// Optional build macro ALU_OP_QUEUE_EDGE_EN: wr_en is synchronised and pushes once per rising edge.
module alu_op_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       wr_a,
  input  logic [3:0]       wr_b,
  input  logic [1:0]       wr_sel,
  input  logic             wr_en,
  input  logic             clr,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [9:0]       mem_q [DEPTH];
  logic [9:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_req_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [9:0]       head_s;

`ifdef ALU_OP_QUEUE_EDGE_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Two-flop synchroniser plus previous-sample flop for rising-edge detection.
  always_comb begin
    sync1_d  = wr_en;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    wr_req_s = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end
`else
  always_comb begin
    wr_req_s = wr_en;
  end
`endif

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == {CNT_W{1'b0}});
    pop_s   = ~empty_s & alu_ready;
    push_s  = wr_req_s & (~full_s | pop_s);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {wr_sel, wr_b, wr_a};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_req_s & full_s & ~pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head word is read straight from storage; zeroed while nothing is queued.
  always_comb begin
    if (empty_s) begin
      head_s = 10'd0;
    end else begin
      head_s = mem_q[rd_ptr_q];
    end
    alu_a     = head_s[3:0];
    alu_b     = head_s[7:4];
    alu_sel   = head_s[9:8];
    alu_valid = ~empty_s;
    count     = count_q;
    full      = full_s;
    empty     = empty_s;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed bench for alu_op_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_alu_op_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       wr_a = 4'd0;
  logic [3:0]       wr_b = 4'd0;
  logic [1:0]       wr_sel = 2'd0;
  logic             wr_en = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_sel;
  logic             alu_valid;
  logic             alu_ready = 1'b0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_a(wr_a), .wr_b(wr_b), .wr_sel(wr_sel),
    .wr_en(wr_en), .clr(clr), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .count(count), .full(full),
    .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {sel,b,a} words and a sticky overflow bit.
  logic [9:0] mq[$];
  bit         m_ovf;
  bit         s1, s2, s3;

  always @(posedge clk or negedge rst_n) begin
    bit req, pop, push;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    end else begin
`ifdef ALU_OP_QUEUE_EDGE_EN
      req = s2 && !s3;
      s3 = s2; s2 = s1; s1 = wr_en;
`else
      req = wr_en;
`endif
      pop  = (mq.size() > 0) && alu_ready;
      push = req && ((mq.size() < DEPTH) || pop);
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (req && mq.size() == DEPTH && !pop) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({wr_sel, wr_b, wr_a});
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [9:0] h;
      h = (mq.size() > 0) ? mq[0] : 10'd0;
      chk("m_valid", int'(alu_valid), int'(mq.size() > 0));
      chk("m_a", int'(alu_a), int'(h[3:0]));
      chk("m_b", int'(alu_b), int'(h[7:4]));
      chk("m_sel", int'(alu_sel), int'(h[9:8]));
      chk("m_count", int'(count), mq.size());
      chk("m_full", int'(full), int'(mq.size() == DEPTH));
      chk("m_empty", int'(empty), int'(mq.size() == 0));
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_cnt_le_depth", int'(count <= CNT_W'(DEPTH)), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s, input logic r);
    wr_en = 1'b1; wr_a = a; wr_b = b; wr_sel = s; alu_ready = r;
    tick();
  endtask

  initial begin
    int next_exp;
    // Reset held with wr_en asserted
    wr_en = 1'b1; wr_a = 4'd7; wr_b = 4'd7; wr_sel = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; wr_en = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(alu_valid), 0);
    chk("rst_abs", int'({alu_sel, alu_b, alu_a}), 0);
    chk("rst_full", int'(full), 0);

    // Two pushes, head held while ALU not ready
    push(4'h3, 4'h5, 2'b00, 1'b0);
    push(4'hF, 4'h1, 2'b10, 1'b0);
    wr_en = 1'b0;
    chk("two_count", int'(count), 2);
    repeat (2) begin
      tick();
      chk("hold_a", int'(alu_a), 3);
      chk("hold_b", int'(alu_b), 5);
      chk("hold_sel", int'(alu_sel), 0);
    end
    alu_ready = 1'b1;
    tick();
    chk("second_a", int'(alu_a), 15);
    chk("second_b", int'(alu_b), 1);
    chk("second_sel", int'(alu_sel), 2);
    tick();
    chk("drained_empty", int'(empty), 1);
    alu_ready = 1'b0;

    // Fill to DEPTH, drop a fifth push, drain in order
    for (int i = 1; i <= 4; i++) push(4'(i), 4'(i), 2'(i), 1'b0);
    push(4'd5, 4'd5, 2'd1, 1'b0);
    wr_en = 1'b0;
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(overflow), 1);
    chk("fill_count", int'(count), 4);
    alu_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("fill_order", int'(alu_a), i);
      tick();
    end
    chk("fill_drained", int'(empty), 1);
    chk("ovf_sticky", int'(overflow), 1);
    alu_ready = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;

    // Full queue with simultaneous push and pop
    for (int i = 6; i <= 9; i++) push(4'(i), 4'(15 - i), 2'(i), 1'b0);
    chk("fp_head", int'(alu_a), 6);
    push(4'hA, 4'h5, 2'd2, 1'b1);
    wr_en = 1'b0; alu_ready = 1'b0;
    chk("fp_count", int'(count), 4);
    chk("fp_head_adv", int'(alu_a), 7);
    chk("fp_ovf", int'(overflow), 0);
    alu_ready = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      chk("fp_order", int'(alu_a), i);
      tick();
    end
    alu_ready = 1'b0;

    // Interleaved pushes and pops across the pointer wrap
    next_exp = 1;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_a = 4'(k + 1); wr_b = 4'(12 - k); wr_sel = 2'(k);
      alu_ready = 1'(k % 2);
      if (alu_valid && alu_ready) begin
        chk("wrap_order", int'(alu_a), next_exp);
        next_exp++;
      end
      tick();
    end
    wr_en = 1'b0; alu_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (alu_valid) begin
        chk("wrap_order", int'(alu_a), next_exp);
        next_exp++;
      end
      tick();
    end
    chk("wrap_total", next_exp, 7);
    alu_ready = 1'b0;

    // clr wins over push and pop
    for (int i = 1; i <= 5; i++) push(4'(i), 4'd0, 2'd3, 1'b0);
    wr_en = 1'b0; alu_ready = 1'b1;
    tick();
    chk("pre_clr_count", int'(count), 3);
    chk("pre_clr_ovf", int'(overflow), 1);
    clr = 1'b1; wr_en = 1'b1; wr_a = 4'd9; alu_ready = 1'b1;
    tick();
    clr = 1'b0; wr_en = 1'b0; alu_ready = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_valid", int'(alu_valid), 0);

    // wr_en held high for 10 cycles
    wr_a = 4'd5; wr_b = 4'd6; wr_sel = 2'd1; wr_en = 1'b1;
    repeat (10) tick();
    wr_en = 1'b0;
    repeat (3) tick();
`ifdef ALU_OP_QUEUE_EDGE_EN
    chk("held_count", int'(count), 1);
    chk("held_a", int'(alu_a), 5);
    chk("held_ovf", int'(overflow), 0);
`else
    chk("held_count", int'(count), 4);
    chk("held_ovf", int'(overflow), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
